axil_regfile_slave: RTL and testbench
=====================================

# axil_regfile_slave

AXI-lite slave exposing a bank of 2^LGREGS 32-bit read/write registers, the responder end of the AXI-lite channel set that the master-side formal properties check. It sits behind any AXI-lite master (e.g. the Wishbone-to-AXI bridge output) and provides control/status storage with byte-strobe writes. Every response is legal under the codebase's AXI-lite master property set:
- stable until accepted
- bounded latency
- never EXOKAY
- no response without a request

## Interface
- C_AXI_ADDR_WIDTH, 28: byte address width (AW); must be ≥ LGREGS+2.
- LGREGS, 4: log2 of register count; registers indexed by addr[LGREGS+1:2].
- C_AXI_DATA_WIDTH, 32: fixed, not overridable (DW).

Ports:
- i_clk  in  1  system clock.
- i_axi_reset_n  in  1  asynchronous, active-low reset.
- i_axi_awvalid / o_axi_awready  in/out  1  write address handshake.
- i_axi_awaddr  in  AW  write byte address.
- i_axi_awprot  in  3  ignored.
- i_axi_wvalid / o_axi_wready  in/out  1  write data handshake.
- i_axi_wdata  in  32  write data.
- i_axi_wstrb  in  4  byte enables.
- o_axi_bvalid / i_axi_bready  out/in  1  write response handshake.
- o_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- i_axi_arvalid / o_axi_arready  in/out  1  read address handshake.
- i_axi_araddr  in  AW  read byte address.
- i_axi_arprot  in  3  ignored.
- o_axi_rvalid / i_axi_rready  out/in  1  read response handshake.
- o_axi_rdata  out  32  read data.
- o_axi_rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- o_regs  out  32·2^LGREGS  flat register contents; reg k at bits [32k+31:32k].

## Operation
- Async reset (i_axi_reset_n low), effective immediately:
  - bvalid, rvalid, bresp, rresp, rdata = 0.
  - All registers = 0.
  - All readies low while reset is low.
- Write channel:
  - Accepts only when AW and W are both valid together.
  - o_axi_awready = o_axi_wready = i_axi_awvalid && i_axi_wvalid && (!o_axi_bvalid || i_axi_bready).
  - AW and W therefore always handshake in the same cycle; a lone AW or lone W waits.
- Write decode:
  - in range: awaddr[AW-1:LGREGS+2] == 0.
  - On an in-range accept, each byte n with wstrb[n]=1 updates reg[idx][8n+7:8n].
  - Bytes with wstrb[n]=0 are unchanged; wstrb=0 is legal, changes nothing, and responds OKAY.
  - Out-of-range: no register changes; bresp = 10.
- Write response:
  - o_axi_bvalid rises the cycle after accept.
  - Holds, with bresp stable, until bvalid && bready.
  - A new accept in the same cycle as B-ack keeps bvalid high with the new bresp.
- Read channel:
  - o_axi_arready = !o_axi_rvalid || i_axi_rready (independent of arvalid).
  - On accept: rdata = reg[idx] and rresp = 00 if in range; otherwise rdata = 0 and rresp = 10.
  - rdata/rresp are registered; they hold while rvalid && !rready.
- Simultaneous read and write to the same register in the same cycle: the read returns the pre-write value.
- Address bits [1:0] are ignored.
- At most one write and one read response outstanding, so outstanding counts stay ≤ 1.

## Timing
- Write latency: accept at edge N; bvalid high after edge N; register value visible on o_regs after edge N.
- Read latency: accept at edge N; rvalid, rdata, and rresp valid after edge N.
- Full throughput: one write and one read per cycle when bready/rready are held high.
- No stall beyond master/back-pressure:
  - awready/wready is high whenever both valids are high and the B slot is free.
  - arready is high whenever the R slot is free.
  - This meets any F_AXI_MAXWAIT ≥ 1 given a responsive master.
- Responses appear exactly 1 cycle after the request, so any F_AXI_MAXDELAY ≥ 2 holds.
- bvalid/rvalid never assert without a prior accepted request.
- bresp/rresp are never 01.
- Reset asserted mid-transaction:
  - Pending responses are dropped (valids forced 0 asynchronously).
  - Registers are cleared.
  - First accept is possible on the first clock edge after reset release.

## Test plan
- Reset: hold reset low 16 cycles, release → all o_regs 0, bvalid=rvalid=0; read addr 0x4 → rdata=0, rresp=00 one cycle after accept.
- Strobed write: write 0xDEADBEEF to 0x8 with wstrb=4'b1111, then 0x00001234 with wstrb=4'b0011 → read 0x8 returns 0xDEAD1234, both bresp=00.
- Out-of-range: LGREGS=4, write 0x40 with data 0xFFFFFFFF → bresp=10, all o_regs unchanged; read 0x40 → rdata=0, rresp=10.
- Back-pressure: hold bready=0 after a write → bvalid/bresp stable, awready/wready=0 for 5 cycles despite a second AW+W; raise bready → second write accepted that cycle, bvalid stays high.
- Split channels: awvalid alone for 3 cycles, then wvalid → no handshake until both are valid; single bvalid pulse follows.
- Same-cycle R/W: reg1=0x11111111; in one cycle, write 0x22222222 to 0x4 and read 0x4 → rdata=0x11111111; next read → 0x22222222.

Source files
------------

// File: rtl/axil_regfile_slave.sv
// AXI-lite slave fronting 2^LGREGS byte-strobed 32-bit registers.
// Single-cycle responses; a write needs AW and W presented together.
module axil_regfile_slave #(
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int LGREGS           = 4
) (
  input  logic                              i_clk,
  input  logic                              i_axi_reset_n,
  input  logic                              i_axi_awvalid,
  output logic                              o_axi_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]       i_axi_awaddr,
  input  logic [2:0]                        i_axi_awprot,
  input  logic                              i_axi_wvalid,
  output logic                              o_axi_wready,
  input  logic [31:0]                       i_axi_wdata,
  input  logic [3:0]                        i_axi_wstrb,
  output logic                              o_axi_bvalid,
  input  logic                              i_axi_bready,
  output logic [1:0]                        o_axi_bresp,
  input  logic                              i_axi_arvalid,
  output logic                              o_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]       i_axi_araddr,
  input  logic [2:0]                        i_axi_arprot,
  output logic                              o_axi_rvalid,
  input  logic                              i_axi_rready,
  output logic [31:0]                       o_axi_rdata,
  output logic [1:0]                        o_axi_rresp,
  output logic [32*(1<<LGREGS)-1:0]         o_regs
);

  localparam int DW    = 32;
  localparam int NREGS = 1 << LGREGS;
  localparam int AW    = C_AXI_ADDR_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [NREGS-1:0][DW-1:0] regs_q, regs_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic              wr_accept, rd_accept;
  logic              aw_in_range, ar_in_range;
  logic              wr_hit;
  logic [LGREGS-1:0] aw_idx, ar_idx;
  logic [DW-1:0]     wmask;
  logic              unused;

  assign unused = ^{i_axi_awprot, i_axi_arprot, i_axi_awaddr[1:0], i_axi_araddr[1:0]};

  // Readies are held low during reset, independent of the valids.
  assign o_axi_awready = i_axi_reset_n && i_axi_awvalid && i_axi_wvalid
                         && (!bvalid_q || i_axi_bready);
  assign o_axi_wready  = o_axi_awready;
  assign o_axi_arready = i_axi_reset_n && (!rvalid_q || i_axi_rready);

  assign wr_accept = o_axi_awready;
  assign rd_accept = i_axi_arvalid && o_axi_arready;

  assign aw_in_range = (i_axi_awaddr[AW-1:LGREGS+2] == '0);
  assign ar_in_range = (i_axi_araddr[AW-1:LGREGS+2] == '0);
  assign aw_idx      = i_axi_awaddr[LGREGS+1:2];
  assign ar_idx      = i_axi_araddr[LGREGS+1:2];
  assign wr_hit      = wr_accept && aw_in_range;

  genvar gi;
  generate
    for (gi = 0; gi < DW/8; gi++) begin : g_mask
      assign wmask[8*gi +: 8] = {8{i_axi_wstrb[gi]}};
    end
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      assign regs_d[gi] = (wr_hit && aw_idx == LGREGS'(gi))
                          ? ((regs_q[gi] & ~wmask) | (i_axi_wdata & wmask))
                          : regs_q[gi];
    end
  endgenerate

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (wr_accept) begin
      bvalid_d = 1'b1;
      bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (i_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Read samples regs_q, so a same-cycle write to that register is not seen.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rd_accept) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = ar_in_range ? regs_q[ar_idx] : '0;
    end else if (i_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      regs_q   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      regs_q   <= regs_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_axi_bvalid = bvalid_q;
  assign o_axi_bresp  = bresp_q;
  assign o_axi_rvalid = rvalid_q;
  assign o_axi_rresp  = rresp_q;
  assign o_axi_rdata  = rdata_q;
  assign o_regs       = regs_q;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed bench for axil_regfile_slave: vector table plus handshake corner cases.
module tb_axil_regfile_slave;

  localparam int AW    = 28;
  localparam int LG    = 4;
  localparam int RW    = 32 * (1 << LG);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [RW-1:0] regs;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  axil_regfile_slave #(.C_AXI_ADDR_WIDTH(AW), .LGREGS(LG)) dut (
    .i_clk(clk), .i_axi_reset_n(rst_n),
    .i_axi_awvalid(awvalid), .o_axi_awready(awready), .i_axi_awaddr(awaddr),
    .i_axi_awprot(3'b000),
    .i_axi_wvalid(wvalid), .o_axi_wready(wready), .i_axi_wdata(wdata), .i_axi_wstrb(wstrb),
    .o_axi_bvalid(bvalid), .i_axi_bready(bready), .o_axi_bresp(bresp),
    .i_axi_arvalid(arvalid), .o_axi_arready(arready), .i_axi_araddr(araddr),
    .i_axi_arprot(3'b000),
    .o_axi_rvalid(rvalid), .i_axi_rready(rready), .o_axi_rdata(rdata), .o_axi_rresp(rresp),
    .o_regs(regs)
  );

  typedef struct {
    bit          wr;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_w(input logic [27:0] a, input logic [31:0] d, input logic [3:0] s);
    awvalid = 1; wvalid = 1; awaddr = a; wdata = d; wstrb = s;
  endtask

  task automatic idle_w();
    awvalid = 0; wvalid = 0;
  endtask

  task automatic write_t(input logic [27:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] exp_resp);
    drive_w(a, d, s);
    #1;
    for (int i = 0; i < 20 && !(awready && wready); i++) tick();
    chk("w_ready", {awready, wready}, 2'b11);
    tick();
    idle_w();
    chk("bvalid", bvalid, 1'b1);
    chk("bresp", bresp, exp_resp);
    tick();
    chk("bvalid_drop", bvalid, 1'b0);
  endtask

  task automatic read_t(input logic [27:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp);
    arvalid = 1; araddr = a;
    #1;
    for (int i = 0; i < 20 && !arready; i++) tick();
    chk("ar_ready", arready, 1'b1);
    tick();
    arvalid = 0;
    chk("rvalid", rvalid, 1'b1);
    chk("rdata", rdata, exp_d);
    chk("rresp", rresp, exp_resp);
    tick();
  endtask

  vec_t vecs[12];
  logic [RW-1:0] exp_regs;

  initial begin
    vecs[0]  = '{1'b1, 28'h0000008, 32'hDEADBEEF, 4'b1111, 2'b00, 32'h0};
    vecs[1]  = '{1'b1, 28'h0000008, 32'h00001234, 4'b0011, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 28'h0000008, 32'h0,        4'b0000, 2'b00, 32'hDEAD1234};
    vecs[3]  = '{1'b1, 28'h0000040, 32'hFFFFFFFF, 4'b1111, 2'b10, 32'h0};
    vecs[4]  = '{1'b0, 28'h0000040, 32'h0,        4'b0000, 2'b10, 32'h0};
    vecs[5]  = '{1'b1, 28'h000000C, 32'hA5A5A5A5, 4'b0000, 2'b00, 32'h0};
    vecs[6]  = '{1'b0, 28'h000000C, 32'h0,        4'b0000, 2'b00, 32'h0};
    vecs[7]  = '{1'b1, 28'h000003F, 32'h12345678, 4'b1100, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 28'h000003D, 32'h0,        4'b0000, 2'b00, 32'h12340000};
    vecs[9]  = '{1'b1, 28'h8000004, 32'h77777777, 4'b1111, 2'b10, 32'h0};
    vecs[10] = '{1'b0, 28'h0000004, 32'h0,        4'b0000, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 28'hFFFFFFC, 32'h0,        4'b0000, 2'b10, 32'h0};

    // Reset held 16 cycles; readies must stay low throughout.
    arvalid = 1; drive_w(28'h4, 32'h1, 4'hF);
    repeat (16) tick();
    chk("rst_arready", arready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    arvalid = 0; idle_w();
    rst_n = 1;
    chk("rst_regs", regs, '0);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    read_t(28'h4, 32'h0, 2'b00);

    for (int i = 0; i < 12; i++) begin
      $display("vec %0d: %s addr=%07h data=%08h strb=%b", i, vecs[i].wr ? "WR" : "RD",
               vecs[i].addr, vecs[i].data, vecs[i].strb);
      if (vecs[i].wr) write_t(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
      else            read_t(vecs[i].addr, vecs[i].rdata, vecs[i].resp);
    end
    exp_regs = '0;
    exp_regs[2*32 +: 32]  = 32'hDEAD1234;
    exp_regs[15*32 +: 32] = 32'h12340000;
    chk("table_regs", regs, exp_regs);

    // Back-pressure on B: second write must stall while bready is low.
    $display("seq: B back-pressure");
    bready = 0;
    drive_w(28'h14, 32'hAAAA0000, 4'hF);
    #1 chk("bp_first_ready", awready, 1'b1);
    tick();
    drive_w(28'h44, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_stall", {awready, wready}, 2'b00);
      chk("bp_hold", {bvalid, bresp}, 3'b100);
      tick();
    end
    exp_regs[5*32 +: 32] = 32'hAAAA0000;
    chk("bp_regs", regs, exp_regs);
    bready = 1;
    #1 chk("bp_release_ready", {awready, wready}, 2'b11);
    tick();
    idle_w();
    chk("bp_second_b", {bvalid, bresp}, 3'b110);
    tick();
    chk("bp_drain", bvalid, 1'b0);
    chk("bp_regs2", regs, exp_regs);

    // Lone AW must wait for W.
    $display("seq: split AW/W");
    awvalid = 1; awaddr = 28'h18; wdata = 32'h0000BEEF; wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("split_wait", {awready, wready, bvalid}, 3'b000);
      tick();
    end
    wvalid = 1;
    #1 chk("split_ready", {awready, wready}, 2'b11);
    tick();
    idle_w();
    chk("split_b", {bvalid, bresp}, 3'b100);
    tick();
    chk("split_pulse", bvalid, 1'b0);
    exp_regs[6*32 +: 32] = 32'h0000BEEF;
    chk("split_regs", regs, exp_regs);

    // Same-cycle read and write of one register returns the old value.
    $display("seq: same-cycle R/W");
    write_t(28'h4, 32'h11111111, 4'hF, 2'b00);
    drive_w(28'h4, 32'h22222222, 4'hF);
    arvalid = 1; araddr = 28'h4;
    tick();
    idle_w(); arvalid = 0;
    chk("rw_old", {rvalid, bvalid, rdata}, {2'b11, 32'h11111111});
    tick();
    read_t(28'h4, 32'h22222222, 2'b00);

    // R back-pressure: rdata held while rready is low.
    $display("seq: R back-pressure");
    rready = 0; arvalid = 1; araddr = 28'h8;
    tick();
    arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rbp_hold", {rvalid, arready, rdata, rresp}, {2'b10, 32'hDEAD1234, 2'b00});
      tick();
    end
    rready = 1;
    #1 chk("rbp_arready", arready, 1'b1);
    tick();
    chk("rbp_drop", rvalid, 1'b0);

    // Reset mid-response clears everything without waiting for a clock.
    $display("seq: async reset mid-transaction");
    bready = 0;
    drive_w(28'h8, 32'h55555555, 4'hF);
    @(posedge clk);
    #3 idle_w();
    chk("mid_pending", bvalid, 1'b1);
    rst_n = 0;
    #1 chk("mid_rst_b", bvalid, 1'b0);
    chk("mid_rst_regs", regs, '0);
    tick();
    tick();
    rst_n = 1; bready = 1;
    read_t(28'h8, 32'h0, 2'b00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
